// File: rtl/io_in_reg_bank.sv
// io_in_reg_bank: multi-channel pad input register with optional hold delay,
// synchroniser chain, glitch filter, change strobe and per-channel bypass.
module io_in_reg_bank #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FIXHOLD_DELAY = 1,
    parameter int unsigned FILTER_BITS   = 4
) (
    input  logic                   IQC,
    input  logic                   QRT,
    input  logic                   CE,
    input  logic [WIDTH-1:0]       A2F,
    input  logic [WIDTH-1:0]       ISEL,
    input  logic [WIDTH-1:0]       FIXHOLD,
    input  logic                   FILT_EN,
    input  logic [FILTER_BITS-1:0] FILT_LEN,
    output logic [WIDTH-1:0]       IQZ,
    output logic [WIDTH-1:0]       CHG
);
    logic [WIDTH-1:0]       dly_q  [FIXHOLD_DELAY];
    logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
    logic [FILTER_BITS-1:0] cnt_q  [WIDTH];
    logic [WIDTH-1:0]       sync_in;
    logic [WIDTH-1:0]       sync_out;
    logic [WIDTH-1:0]       filt_q;
    logic [WIDTH-1:0]       chg_q;
    logic [FILTER_BITS:0]   len_eff;

    // A programmed length of zero behaves like one.
    always_comb begin
        len_eff = {1'b0, FILT_LEN};
        if (FILT_LEN == '0) begin
            len_eff = (FILTER_BITS+1)'(1);
        end
    end

    assign sync_in  = (FIXHOLD & dly_q[FIXHOLD_DELAY-1]) | (~FIXHOLD & A2F);
    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge IQC) begin
        if (QRT) begin
            for (int unsigned s = 0; s < FIXHOLD_DELAY; s++) begin
                dly_q[s] <= '0;
            end
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            filt_q <= '0;
            chg_q  <= '0;
        end else if (CE) begin
            dly_q[0] <= A2F;
            for (int unsigned s = 1; s < FIXHOLD_DELAY; s++) begin
                dly_q[s] <= dly_q[s-1];
            end
            sync_q[0] <= sync_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync_out[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                    chg_q[i] <= 1'b0;
                end else if (!FILT_EN || ({1'b0, cnt_q[i]} + (FILTER_BITS+1)'(1)) >= len_eff) begin
                    filt_q[i] <= sync_out[i];
                    cnt_q[i]  <= '0;
                    chg_q[i]  <= 1'b1;
                end else begin
                    cnt_q[i] <= cnt_q[i] + FILTER_BITS'(1);
                    chg_q[i] <= 1'b0;
                end
            end
        end else begin
            // Clearing the strobe here keeps a held pulse from reappearing when CE returns.
            chg_q <= '0;
        end
    end

    assign IQZ = (ISEL & A2F) | (~ISEL & filt_q);
    assign CHG = chg_q & {WIDTH{CE}};
endmodule

// File: tb/tb_io_in_reg_bank.sv
// Scoreboard bench for io_in_reg_bank: a queue-based reference model predicts
// filtered state and strobes; a negedge monitor checks IQZ and CHG.
module tb_io_in_reg_bank;
    localparam int unsigned W  = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned FD = 1;
    localparam int unsigned FB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [W-1:0]  a2f;
    logic [W-1:0]  isel;
    logic [W-1:0]  fixhold;
    logic          filt_en;
    logic [FB-1:0] filt_len;
    logic [W-1:0]  iqz;
    logic [W-1:0]  chg;

    always #5 clk = ~clk;

    io_in_reg_bank #(
        .WIDTH(W),
        .SYNC_STAGES(SS),
        .FIXHOLD_DELAY(FD),
        .FILTER_BITS(FB)
    ) dut (
        .IQC(clk),
        .QRT(rst),
        .CE(ce),
        .A2F(a2f),
        .ISEL(isel),
        .FIXHOLD(fixhold),
        .FILT_EN(filt_en),
        .FILT_LEN(filt_len),
        .IQZ(iqz),
        .CHG(chg)
    );

    typedef struct packed {
        logic [W-1:0] filt;
        logic [W-1:0] chg;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;

    // Reference model: history queues hold the values seen N enabled edges ago.
    logic [W-1:0] m_dly[$];
    logic [W-1:0] m_sync[$];
    logic [W-1:0] m_filt;
    logic [W-1:0] m_chg;
    int           m_run[W];
    bit           started = 0;

    always @(posedge clk) begin : model
        logic [W-1:0] sq;
        logic [W-1:0] sin;
        int           len;
        if (rst) begin
            m_dly  = {};
            m_sync = {};
            for (int s = 0; s < FD; s++) m_dly.push_back('0);
            for (int s = 0; s < SS; s++) m_sync.push_back('0);
            m_filt = '0;
            m_chg  = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            started = 1;
        end else if (ce && started) begin
            sq  = m_sync[0];
            len = (filt_len == 0) ? 1 : int'(filt_len);
            for (int i = 0; i < W; i++) begin
                sin[i] = fixhold[i] ? m_dly[0][i] : a2f[i];
                if (sq[i] == m_filt[i]) begin
                    m_run[i] = 0;
                    m_chg[i] = 1'b0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                    if (!filt_en || m_run[i] >= len) begin
                        m_filt[i] = sq[i];
                        m_run[i]  = 0;
                        m_chg[i]  = 1'b1;
                    end else begin
                        m_chg[i] = 1'b0;
                    end
                end
            end
            void'(m_sync.pop_front());
            m_sync.push_back(sin);
            void'(m_dly.pop_front());
            m_dly.push_back(a2f);
        end else begin
            m_chg = '0;
        end
        if (started) sbq.push_back({m_filt, m_chg});
    end

    always @(negedge clk) begin : monitor
        exp_t         e;
        logic [W-1:0] ei;
        logic [W-1:0] ec;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            for (int i = 0; i < W; i++) ei[i] = isel[i] ? a2f[i] : e.filt[i];
            ec = ce ? e.chg : '0;
            total++;
            if (iqz !== ei) begin
                bad++;
                $display("FAIL iqz t=%0t got=%b want=%b", $time, iqz, ei);
            end
            total++;
            if (chg !== ec) begin
                bad++;
                $display("FAIL chg t=%0t got=%b want=%b", $time, chg, ec);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse0(input int hi, input int gap);
        a2f[0] = 1'b1;
        cycles(hi);
        a2f[0] = 1'b0;
        cycles(gap);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; a2f = 4'hF; isel = 4'b0001;
        fixhold = '0; filt_en = 1'b0; filt_len = '0;
        cycles(2);
        rst = 1'b0; isel = '0;
        cycles(4);

        a2f = '0; cycles(4);
        fixhold = 4'b0010; a2f = 4'b0011;
        cycles(6);

        a2f = '0; fixhold = '0; filt_en = 1'b1; filt_len = 4'd4;
        cycles(8);
        pulse0(3, 8);
        pulse0(4, 10);
        pulse0(2, 1);
        pulse0(3, 10);

        filt_len = 4'd0;
        pulse0(1, 6);
        filt_len = 4'd8;
        a2f[0] = 1'b1;
        cycles(5);
        filt_len = 4'd2;
        cycles(6);
        a2f[0] = 1'b0; filt_len = 4'd4;
        cycles(8);

        a2f[1] = 1'b1;
        cycles(3);
        ce = 1'b0; cycles(5);
        ce = 1'b1; cycles(8);
        a2f[2] = 1'b1;
        cycles(4);
        ce = 1'b0; rst = 1'b1;
        cycles(1);
        rst = 1'b0; ce = 1'b1;
        cycles(8);

        isel[3] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a2f[3] = ~a2f[3];
            cycles(1);
        end
        isel[3] = 1'b0;
        cycles(6);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) == 0) a2f[$urandom_range(W-1)] ^= 1'b1;
            if ($urandom_range(15) == 0) isel = W'($urandom);
            if ($urandom_range(31) == 0) fixhold = W'($urandom);
            if ($urandom_range(31) == 0) filt_en = 1'($urandom);
            if ($urandom_range(31) == 0) filt_len = FB'($urandom);
            ce  = ($urandom_range(7) != 0);
            rst = ($urandom_range(99) == 0);
            cycles(1);
        end
        rst = 1'b0; ce = 1'b1;
        cycles(4);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
